// File: rtl/systolic_drain_if.sv
// Write port toward the m2 result memory: one tile row per word, with ready backpressure.
interface systolic_drain_if #(
    parameter int unsigned N       = 3,
    parameter int unsigned D_W_ACC = 16,
    parameter int unsigned M       = 6
);
    localparam int unsigned AW = $clog2(M * M / N);

    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic [N*D_W_ACC-1:0] wr_data;
    logic                 wr_ready;

    modport master (output wr_en, output wr_addr, output wr_data, input wr_ready);
    modport slave  (input wr_en, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/systolic_drain.sv
// Collects the diagonal wavefront of PE accumulators into a ping-pong tile buffer and drains
// each completed N x N tile row by row into the m2 memory.
module systolic_drain #(
    parameter int unsigned D_W_ACC = 16,
    parameter int unsigned N       = 3,
    parameter int unsigned M       = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [D_W_ACC-1:0]  D [N][N],
    input  logic [N-1:0]        valid_D [N],
    systolic_drain_if.master    wr,
    output logic                tile_done,
    output logic                mat_done,
    output logic                overflow
);
    localparam int unsigned TPR = M / N;
    localparam int unsigned T   = TPR * TPR;
    localparam int unsigned AW  = $clog2(M * M / N);
    localparam int unsigned RW  = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned TW  = (T > 1) ? $clog2(T) : 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    // Partial tile is staged apart from the banks so capture never disturbs a bank being drained.
    logic [D_W_ACC-1:0] stage_q [N][N];
    logic [D_W_ACC-1:0] bank_q  [2][N][N];
    logic [N-1:0]       mask_q  [N];
    logic [1:0]         full_q, full_d;
    logic               fill_bank_q, drain_bank_q;
    logic [0:0]         state_q;
    logic [RW-1:0]      row_q;
    logic [TW-1:0]      tile_cnt_q;
    logic               tile_done_q, mat_done_q, overflow_q;

    logic [N-1:0]       take     [N];
    logic [N-1:0]       mask_nxt [N];
    logic               dup, complete, accept, last_row, store, discard;
    logic [N*D_W_ACC-1:0] row_data;
    int unsigned        addr_full;

    always_comb begin
        dup      = 1'b0;
        complete = 1'b1;
        for (int i = 0; i < N; i++) begin
            take[i]     = valid_D[i] & ~mask_q[i];
            mask_nxt[i] = mask_q[i] | valid_D[i];
            if (|(valid_D[i] & mask_q[i])) dup = 1'b1;
            if (!(&mask_nxt[i])) complete = 1'b0;
        end
    end

    assign accept   = wr.wr_en && wr.wr_ready;
    assign last_row = (row_q == RW'(N - 1));

    // A bank freed this cycle is available to the tile completing this cycle.
    always_comb begin
        full_d = full_q;
        if (accept && last_row) full_d[drain_bank_q] = 1'b0;
        store   = complete && !full_d[fill_bank_q];
        discard = complete && full_d[fill_bank_q];
        if (store) full_d[fill_bank_q] = 1'b1;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (take[i][j]) stage_q[i][j] <= D[i][j];
                if (store) bank_q[fill_bank_q][i][j] <= take[i][j] ? D[i][j] : stage_q[i][j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q       <= '0;
            fill_bank_q  <= 1'b0;
            drain_bank_q <= 1'b0;
            state_q      <= IDLE;
            row_q        <= '0;
            tile_cnt_q   <= '0;
            tile_done_q  <= 1'b0;
            mat_done_q   <= 1'b0;
            overflow_q   <= 1'b0;
            for (int i = 0; i < N; i++) mask_q[i] <= '0;
        end else begin
            full_q      <= full_d;
            tile_done_q <= 1'b0;
            mat_done_q  <= 1'b0;
            if (dup || discard) overflow_q <= 1'b1;
            for (int i = 0; i < N; i++) mask_q[i] <= complete ? '0 : mask_nxt[i];
            if (store) fill_bank_q <= ~fill_bank_q;

            case (state_q)
                IDLE: begin
                    if (full_q[drain_bank_q]) begin
                        state_q <= DRAIN;
                        row_q   <= '0;
                    end
                end
                DRAIN: begin
                    if (accept) begin
                        if (last_row) begin
                            row_q        <= '0;
                            drain_bank_q <= ~drain_bank_q;
                            tile_done_q  <= 1'b1;
                            if (tile_cnt_q == TW'(T - 1)) begin
                                mat_done_q <= 1'b1;
                                tile_cnt_q <= '0;
                            end else begin
                                tile_cnt_q <= tile_cnt_q + 1'b1;
                            end
                            state_q <= full_q[~drain_bank_q] ? DRAIN : IDLE;
                        end else begin
                            row_q <= row_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        row_data  = '0;
        addr_full = 0;
        if (state_q == DRAIN) begin
            for (int j = 0; j < N; j++) row_data[j*D_W_ACC +: D_W_ACC] = bank_q[drain_bank_q][row_q][j];
            addr_full = ((32'(tile_cnt_q) / TPR) * N + 32'(row_q)) * TPR + 32'(tile_cnt_q) % TPR;
        end
    end

    assign wr.wr_en   = (state_q == DRAIN);
    assign wr.wr_addr = AW'(addr_full);
    assign wr.wr_data = row_data;
    assign tile_done  = tile_done_q;
    assign mat_done   = mat_done_q;
    assign overflow   = overflow_q;
endmodule

// File: tb/tb_systolic_drain.sv
// Randomized bench for systolic_drain: a tile-level queue model predicts every output each cycle,
// and literal address/data expectations from the directed scenarios pin that model down.
module tb_systolic_drain;
    localparam int unsigned N  = 3;
    localparam int unsigned M  = 6;
    localparam int unsigned DW = 16;
    localparam int unsigned AW = 4;
    localparam int unsigned T  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] D [N][N];
    logic [N-1:0]  valid_D [N];
    logic          tile_done, mat_done, overflow;

    systolic_drain_if #(.N(N), .D_W_ACC(DW), .M(M)) wbus ();

    systolic_drain #(.D_W_ACC(DW), .N(N), .M(M)) dut (
        .clk       (clk),
        .rst       (rst),
        .D         (D),
        .valid_D   (valid_D),
        .wr        (wbus),
        .tile_done (tile_done),
        .mat_done  (mat_done),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int fails   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [AW-1:0]   addr;
        logic [N*DW-1:0] data;
        bit              last;
        bit              md;
        int              avail;
    } word_t;

    word_t         q[$];
    bit            mmask [N][N];
    logic [DW-1:0] mval  [N][N];
    int            held, pushed, cyc;
    bit            movf, exp_td, exp_md, on, after_rst, exp_en;

    logic [AW-1:0]   log_addr[$];
    logic [N*DW-1:0] log_data[$];
    int              td_seen, md_seen;

    always @(negedge clk) begin
        word_t w;
        bit    full;
        int    tn, ti, tj;
        exp_en = on && (q.size() > 0) && (cyc >= q[0].avail);
        if (on) begin
            chk("wr_en", wbus.wr_en, exp_en);
            if (exp_en) begin
                chk("wr_addr", wbus.wr_addr, q[0].addr);
                chk("wr_data", wbus.wr_data, q[0].data);
            end else if (after_rst) begin
                chk("rst_addr", wbus.wr_addr, 0);
                chk("rst_data", wbus.wr_data, 0);
            end
            chk("tile_done", tile_done, exp_td);
            chk("mat_done", mat_done, exp_md);
            chk("overflow", overflow, movf);
            if (wbus.wr_en && wbus.wr_ready) begin
                log_addr.push_back(wbus.wr_addr);
                log_data.push_back(wbus.wr_data);
            end
            if (tile_done) td_seen++;
            if (mat_done) md_seen++;
        end
        after_rst = 1'b0;
        if (rst) begin
            q.delete();
            held = 0; pushed = 0; movf = 0; exp_td = 0; exp_md = 0;
            for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) mmask[i][j] = 0;
            on = 1'b1;
            after_rst = 1'b1;
        end else if (on) begin
            exp_td = 0; exp_md = 0;
            if (exp_en && wbus.wr_ready) begin
                w = q.pop_front();
                if (w.last) begin
                    held--;
                    exp_td = 1;
                    exp_md = w.md;
                end
            end
            full = 1;
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    if (valid_D[i][j]) begin
                        if (mmask[i][j]) movf = 1;
                        else begin
                            mmask[i][j] = 1;
                            mval[i][j]  = D[i][j];
                        end
                    end
                    if (!mmask[i][j]) full = 0;
                end
            end
            if (full) begin
                for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) mmask[i][j] = 0;
                if (held == 2) movf = 1;
                else begin
                    held++;
                    tn = pushed % T;
                    pushed++;
                    ti = tn / (M / N);
                    tj = tn % (M / N);
                    for (int r = 0; r < N; r++) begin
                        w.addr = AW'((ti * N + r) * (M / N) + tj);
                        for (int j = 0; j < N; j++) w.data[j*DW +: DW] = mval[r][j];
                        w.last  = (r == N - 1);
                        w.md    = (tn == T - 1);
                        w.avail = cyc + 2;
                        q.push_back(w);
                    end
                end
            end
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    bit rand_rdy = 0;

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                valid_D[i][j] = 1'b0;
                D[i][j] = DW'($urandom);
            end
        if (rand_rdy) wbus.wr_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        log_addr.delete();
        log_data.delete();
        td_seen = 0;
        md_seen = 0;
    endtask

    task automatic wavefront(input bit pat, input bit dup11);
        for (int k = 0; k < 2 * N - 1; k++) begin
            step();
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    if (i + j == k) begin
                        valid_D[i][j] = 1'b1;
                        D[i][j] = pat ? DW'(10 * i + j) : DW'($urandom);
                    end
            if (dup11 && k == 2 * N - 2) valid_D[1][1] = 1'b1;
        end
    endtask

    task automatic scatter_tile(input bit dup);
        int slot [N][N];
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) slot[i][j] = $urandom_range(0, 5);
        for (int s = 0; s < 6; s++) begin
            step();
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    if (slot[i][j] == s || (dup && s == 5 && i == 0 && j == 0 && slot[0][0] < 5))
                        valid_D[i][j] = 1'b1;
        end
    endtask

    task automatic drain_wait(input string name, input int want);
        int n = 0;
        while (log_addr.size() < want && n < 200) begin
            step();
            n++;
        end
        chk(name, log_addr.size(), want);
    endtask

    int exp_a [12] = '{0, 2, 4, 1, 3, 5, 6, 8, 10, 7, 9, 11};

    initial begin
        rst = 1'b1;
        wbus.wr_ready = 1'b1;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                valid_D[i][j] = 1'b0;
                D[i][j] = '0;
            end
        steps(2);
        rst = 1'b0;

        // Single tile with D = 10*i + j.
        do_reset();
        wavefront(1, 0);
        drain_wait("t1_count", 3);
        steps(4);
        chk("t1_addr0", log_addr[0], 0);
        chk("t1_data0", log_data[0], 48'h0002_0001_0000);
        chk("t1_addr1", log_addr[1], 2);
        chk("t1_data1", log_data[1], 48'h000c_000b_000a);
        chk("t1_addr2", log_addr[2], 4);
        chk("t1_data2", log_data[2], 48'h0016_0015_0014);
        chk("t1_tile_done", td_seen, 1);
        chk("t1_overflow", overflow, 0);

        // Four tiles back to back, then a fifth to show tile_cnt wrapped.
        do_reset();
        for (int t = 0; t < 5; t++) wavefront(0, 0);
        drain_wait("t2_count", 15);
        steps(4);
        for (int k = 0; k < 12; k++) chk("t2_addr", log_addr[k], exp_a[k]);
        chk("t2_wrap_addr", log_addr[12], 0);
        chk("t2_mat_done", md_seen, 1);
        chk("t2_tile_done", td_seen, 5);

        // Backpressure for 5 cycles mid-tile while the next tile is captured.
        do_reset();
        wavefront(0, 0);
        drain_wait("t3_first", 1);
        wbus.wr_ready = 1'b0;
        wavefront(0, 0);
        wbus.wr_ready = 1'b1;
        drain_wait("t3_count", 6);
        steps(8);
        chk("t3_no_dup", log_addr.size(), 6);
        for (int k = 0; k < 6; k++) chk("t3_addr", log_addr[k], exp_a[k]);

        // Three tiles with the memory stalled: the third is lost.
        do_reset();
        wbus.wr_ready = 1'b0;
        for (int t = 0; t < 3; t++) wavefront(0, 0);
        steps(2);
        chk("t4_overflow", overflow, 1);
        wbus.wr_ready = 1'b1;
        drain_wait("t4_count", 6);
        steps(8);
        chk("t4_total", log_addr.size(), 6);
        for (int k = 0; k < 6; k++) chk("t4_addr", log_addr[k], exp_a[k]);
        chk("t4_tile_done", td_seen, 2);

        // Duplicate pulse on PE(1,1): sticky overflow until reset.
        do_reset();
        wavefront(0, 1);
        steps(2);
        chk("t5_overflow", overflow, 1);
        steps(10);
        chk("t5_sticky", overflow, 1);
        do_reset();
        step();
        chk("t5_cleared", overflow, 0);

        // Reset during the row-1 write, then a fresh tile.
        do_reset();
        wavefront(0, 0);
        drain_wait("t6_first", 1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_wr_en", wbus.wr_en, 0);
        chk("t6_tile_done", tile_done, 0);
        log_addr.delete();
        log_data.delete();
        wavefront(0, 0);
        drain_wait("t6_count", 3);
        chk("t6_addr0", log_addr[0], 0);

        // Random capture order, random gaps, random backpressure, occasional duplicates.
        do_reset();
        rand_rdy = 1'b1;
        for (int t = 0; t < 24; t++) begin
            steps($urandom_range(0, 6));
            if ($urandom_range(0, 1) == 1) scatter_tile($urandom_range(0, 7) == 0);
            else wavefront(0, 0);
        end
        rand_rdy = 1'b0;
        wbus.wr_ready = 1'b1;
        steps(30);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
